// File: rtl/harvos_pkg.sv
// Shared types for the harvos instruction-memory interface: responder FSM
// states, the queued request record and the default SRAM base address.
package harvos_pkg;

  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_rsp_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        err;
  } imem_req_s;

endpackage

// File: rtl/imem_req_fifo.sv
// Small synchronous FIFO of fetch requests; push and pop may occur in the
// same cycle (count unchanged). Pop on empty and push on full are not allowed.
module imem_req_fifo
  import harvos_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  imem_req_s                din,
  input  logic                     pop,
  output imem_req_s                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  imem_req_s       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/imem_responder.sv
// Instruction SRAM responder for the icache refill engine; program images are
// written through the load port. Optional macro IMEM_PARITY_EN adds per-word even parity.
module imem_responder
  import harvos_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter int          REQ_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_wdata,
  output logic        ovf,
  output logic [15:0] fault_cnt,
  output logic [1:0]  dbg_state
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = $clog2(REQ_DEPTH) + 1;
  localparam int          LW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int          LAT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // Handshake: mem_req is a one-cycle strobe with no ready; a request arriving
  // with the queue full is dropped (ovf). mem_rvalid is a one-cycle strobe with
  // no back-pressure; mem_fault/mem_rdata are meaningful only while it is high.
  imem_rsp_state_e state, state_next;
  logic [LW-1:0]   lat_cnt, lat_next;
  imem_req_s       req_in, head, rd_entry;
  logic            push, pop, fifo_full, fifo_empty, rd_en;
  logic [CW-1:0]   fifo_cnt;
  logic [31:0]     sram [DEPTH_WORDS];
  logic [31:0]     rd_data;
  logic            rd_err, par_bad, resp_fault;

  assign req_in = '{addr: mem_addr, err: addr_err(mem_addr)};
  assign push   = mem_req && !fifo_full;
  assign pop    = (state == RESP);

  imem_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (req_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // IDLE looks at the incoming request too, so an isolated fetch answers
  // exactly LATENCY cycles after the cycle it was presented.
  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    rd_en      = 1'b0;
    rd_entry   = head;
    case (state)
      IDLE: begin
        if (!fifo_empty || push) begin
          rd_entry = fifo_empty ? req_in : head;
          if (LATENCY == 1) begin
            if (!load_we) begin
              rd_en      = 1'b1;
              state_next = RESP;
            end else begin
              state_next = WAIT;
              lat_next   = '0;
            end
          end else begin
            state_next = WAIT;
            lat_next   = LW'(LAT_INIT);
          end
        end
      end
      WAIT: begin
        if (lat_cnt != '0) begin
          lat_next = lat_cnt - 1'b1;
        end else if (!load_we) begin
          rd_en      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if ((fifo_cnt > CW'(1)) || push) begin
          state_next = WAIT;
          lat_next   = LW'(LAT_INIT);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
    end
  end

  // The FSM never issues a read in a load_we cycle, so no same-address hazard exists.
  always_ff @(posedge clk) begin
    if (load_we && !addr_err(load_addr)) sram[word_idx(load_addr)] <= load_wdata;
    if (rd_en) begin
      rd_data <= sram[word_idx(rd_entry.addr)];
      rd_err  <= rd_entry.err;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH_WORDS];
  logic rd_par;

  always_ff @(posedge clk) begin
    if (load_we && !addr_err(load_addr)) par_mem[word_idx(load_addr)] <= ^load_wdata;
    if (rd_en) rd_par <= par_mem[word_idx(rd_entry.addr)];
  end

  assign par_bad = ((^rd_data) != rd_par);
`else
  assign par_bad = 1'b0;
`endif

  assign resp_fault = rd_err || par_bad;
  assign mem_rvalid = (state == RESP);
  assign mem_fault  = mem_rvalid && resp_fault;
  assign mem_rdata  = (mem_rvalid && !resp_fault) ? rd_data : 32'h0;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      fault_cnt <= '0;
    end else begin
      if (mem_req && fifo_full) ovf <= 1'b1;
      if (pop && resp_fault && (fault_cnt != 16'hFFFF)) fault_cnt <= fault_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: the driver predicts each response from
// a word-array model and an occupancy count; a negedge monitor checks them in order.
module tb_imem_responder;
  import harvos_pkg::*;

  localparam int          DW   = 4096;
  localparam int          LAT  = 2;
  localparam int          RQ   = 2;
  localparam logic [31:0] BASE = IMEM_BASE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_fault;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_wdata = '0;
  logic        ovf;
  logic [15:0] fault_cnt;
  logic [1:0]  dbg_state;

  imem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DW), .LATENCY(LAT), .REQ_DEPTH(RQ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_fault(mem_fault),
    .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
    .ovf(ovf), .fault_cnt(fault_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] model_mem [int];
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          flt_exp = 0;
  logic        ovf_exp = 1'b0;
  int          corrupt_word = -1;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || ({1'b0, a} >= ({1'b0, BASE} + 33'(4 * DW)));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; lat >= 0 means the response must land lat cycles later.
  task automatic step(input logic r, input logic [31:0] a, input logic w,
                      input logic [31:0] la, input logic [31:0] wd, input int lat);
    logic        f;
    logic [31:0] d;
    int          widx;
    mem_req = r; mem_addr = a; load_we = w; load_addr = la; load_wdata = wd;
    if (r) begin
      if (acc_cnt - rsp_cnt < RQ) begin
        widx = int'((a - BASE) / 4);
        f = bad_addr(a) || (widx == corrupt_word);
        d = f ? 32'h0 : (model_mem.exists(widx) ? model_mem[widx] : 32'h0);
        exp_q.push_back({f, d});
        exp_cyc_q.push_back(lat < 0 ? -1 : cyc + lat);
        acc_cnt++;
        if (f) flt_exp++;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    if (w && !bad_addr(la)) model_mem[int'((la - BASE) / 4)] = wd;
    @(posedge clk); #1;
    mem_req = 1'b0; load_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, -1);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] wd);
    step(1'b0, 32'h0, 1'b1, la, wd, -1);
  endtask

  task automatic req(input logic [31:0] a, input int lat);
    step(1'b1, a, 1'b0, 32'h0, 32'h0, lat);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      idle(1);
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
      rsp_cnt = acc_cnt;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    acc_cnt = 0; rsp_cnt = 0; flt_exp = 0; ovf_exp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [32:0] mon_e;
  int          mon_ec;
  always @(negedge clk) begin
    if (rst_n && mem_rvalid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        check("rsp_fault_rdata", {31'h0, mem_fault, mem_rdata}, {31'h0, mon_e});
        if (mon_ec >= 0) check("rsp_latency", 64'(cyc), 64'(mon_ec));
      end
      rsp_cnt++;
    end else if (rst_n && (mem_fault !== 1'b0 || mem_rdata !== 32'h0)) begin
      n_vec++; n_err++;
      $display("FAIL idle_quiet: fault=%0b rdata=%0h expected 0/0", mem_fault, mem_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rvalid", 64'(mem_rvalid), 64'(0));
    check("reset_fault", 64'(mem_fault), 64'(0));
    check("reset_rdata", 64'(mem_rdata), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
    check("reset_fault_cnt", 64'(fault_cnt), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    idle(2);

    // Single fetch after preload
    load(32'h0, 32'hDEAD_BEEF);
    req(32'h0, LAT);
    drain();

    // Refill burst, one request every three cycles
    for (int i = 0; i < 4; i++) load(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i * 32'h111));
    for (int i = 0; i < 4; i++) begin
      req(32'h10 + 32'(4 * i), LAT);
      idle(2);
    end
    drain();

    // Address faults: misaligned, then first word past the array
    req(32'h2, LAT);
    drain();
    check("fault_cnt_misaligned", 64'(fault_cnt), 64'(flt_exp));
    req(BASE + 32'(4 * DW), LAT);
    drain();
    check("fault_cnt_range", 64'(fault_cnt), 64'(flt_exp));

    // Load collides with the read-issue cycle: response slips by one
    req(32'h14, LAT + 1);
    load(32'h20, 32'h1234_5678);
    drain();
    req(32'h20, LAT);
    drain();

    // Three back-to-back requests with a two-entry queue
    req(32'h10, LAT);
    req(32'h14, -1);
    req(32'h18, -1);
    drain();
    check("ovf_set", 64'(ovf), 64'(ovf_exp));

    // Reset while the read is pending discards it
    req(32'h10, LAT);
    do_reset();
    idle(5);
    check("ovf_after_reset", 64'(ovf), 64'(0));
    check("fault_cnt_after_reset", 64'(fault_cnt), 64'(0));
    check("state_after_reset", 64'(dbg_state), 64'(IDLE));

`ifdef IMEM_PARITY_EN
    load(32'h14, 32'h0F0F_0001);
    idle(1);
    dut.par_mem[5] = ~dut.par_mem[5];
    corrupt_word = 5;
    req(32'h14, LAT);
    drain();
    corrupt_word = -1;
    load(32'h14, 32'h0F0F_0001);
    req(32'h14, LAT);
    drain();
`endif

    // Randomized mix of reads, faults and loads to a disjoint region
    for (int i = 0; i < 16; i++) load(32'(4 * i), $urandom);
    for (int i = 0; i < 400; i++) begin
      logic        r, w;
      logic [31:0] a, la;
      int          k;
      r = ($urandom_range(0, 1) == 1);
      k = $urandom_range(0, 9);
      if (k < 7)       a = 32'(4 * $urandom_range(0, 15));
      else if (k == 7) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (k == 8) a = BASE + 32'(4 * DW) + 32'(4 * $urandom_range(0, 255));
      else             a = $urandom | 32'h8000_0000;
      w = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) la = BASE + 32'(4 * DW) + 32'(4 * $urandom_range(0, 15));
      else                           la = 32'(4 * (256 + $urandom_range(0, 31)));
      step(r, a, w, la, $urandom, -1);
    end
    drain();
    for (int i = 0; i < 32; i++) begin
      if (model_mem.exists(256 + i)) begin
        req(32'(4 * (256 + i)), LAT);
        idle(1);
      end
    end
    drain();
    check("ovf_final", 64'(ovf), 64'(ovf_exp));
    check("fault_cnt_final", 64'(fault_cnt), 64'(flt_exp));
    check("rsp_count_final", 64'(rsp_cnt), 64'(acc_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
